// File: rtl/unified_cache_mem_arbiter.sv
// unified_cache_mem_arbiter: round-robin sharing of one memory packet port, one transaction in flight,
// responses routed back to the granted requester; all outputs registered.
module unified_cache_mem_arbiter #(
  parameter int NUM_REQUESTER = 2,
  parameter int MEM_PACKET_WIDTH_IN_BITS = 32,
  parameter int VALID_POS = 31
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic [NUM_REQUESTER*MEM_PACKET_WIDTH_IN_BITS-1:0] request_packet_flatted_in,
  output logic [NUM_REQUESTER-1:0]                    request_packet_ack_flatted_out,
  output logic [NUM_REQUESTER*MEM_PACKET_WIDTH_IN_BITS-1:0] response_packet_flatted_out,
  input  logic [NUM_REQUESTER-1:0]                    response_packet_ack_flatted_in,
  output logic [MEM_PACKET_WIDTH_IN_BITS-1:0]         to_mem_packet_out,
  input  logic                                        to_mem_packet_ack_in,
  input  logic [MEM_PACKET_WIDTH_IN_BITS-1:0]         from_mem_packet_in,
  output logic                                        from_mem_packet_ack_out,
  output logic                                        busy_out,
  output logic                                        error_out
);
  localparam int N = NUM_REQUESTER;
  localparam int P = MEM_PACKET_WIDTH_IN_BITS;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, owner_q, owner_d, gnt_idx;
  logic gnt_found, mem_vld;
  logic [P-1:0] to_mem_q, to_mem_d;
  logic [N-1:0] req_ack_q, req_ack_d;
  logic [N*P-1:0] resp_q, resp_d;
  logic from_ack_q, from_ack_d, busy_q, busy_d, err_q, err_d;
  // descending scan so the nearest port after last_q overwrites farther ones
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--)
      if (request_packet_flatted_in[((int'(last_q) + k) % N) * P + VALID_POS]) begin
        gnt_found = 1'b1;
        gnt_idx = IW'((int'(last_q) + k) % N);
      end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    to_mem_d = to_mem_q;
    req_ack_d = '0;
    resp_d = resp_q;
    err_d = err_q;
    from_ack_d = 1'b0;
    // a response still held during our ack cycle is the same one, not a new one
    mem_vld = from_mem_packet_in[VALID_POS] && !from_ack_q;
    if (mem_vld) begin
      from_ack_d = 1'b1;
      if (state_q == WAIT_RESP) begin
        resp_d[owner_q*P +: P] = from_mem_packet_in;
        state_d = DELIVER;
      end else err_d = 1'b1;
    end
    if (state_q == IDLE && gnt_found) begin
      owner_d = gnt_idx;
      last_d = gnt_idx;
      to_mem_d = request_packet_flatted_in[gnt_idx*P +: P];
      req_ack_d[gnt_idx] = 1'b1;
      state_d = ISSUE;
    end
    if (state_q == ISSUE && to_mem_packet_ack_in) begin
      to_mem_d = '0;
      state_d = WAIT_RESP;
    end
    if (state_q == DELIVER && response_packet_ack_flatted_in[owner_q]) begin
      resp_d = '0;
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      last_q <= IW'(N - 1);
      owner_q <= '0;
      to_mem_q <= '0;
      req_ack_q <= '0;
      resp_q <= '0;
      from_ack_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      to_mem_q <= to_mem_d;
      req_ack_q <= req_ack_d;
      resp_q <= resp_d;
      from_ack_q <= from_ack_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign request_packet_ack_flatted_out = req_ack_q;
  assign response_packet_flatted_out = resp_q;
  assign to_mem_packet_out = to_mem_q;
  assign from_mem_packet_ack_out = from_ack_q;
  assign busy_out = busy_q;
  assign error_out = err_q;
endmodule

// File: tb/tb_unified_cache_mem_arbiter.sv
// tb_unified_cache_mem_arbiter: directed bench for the two-port arbiter with a small requester/memory model.
module tb_unified_cache_mem_arbiter;
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic [63:0] req = '0;
  logic [1:0] req_ack;
  logic [63:0] resp_out;
  logic [1:0] resp_ack = '0;
  logic [31:0] to_mem;
  logic to_mem_ack = 1'b0;
  logic [31:0] from_mem = '0;
  logic from_ack, busy, err;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int txn = 0;
  int t0;
  bit exp_err = 1'b0;

  unified_cache_mem_arbiter #(.NUM_REQUESTER(2), .MEM_PACKET_WIDTH_IN_BITS(32), .VALID_POS(31)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_packet_flatted_in(req), .request_packet_ack_flatted_out(req_ack),
    .response_packet_flatted_out(resp_out), .response_packet_ack_flatted_in(resp_ack),
    .to_mem_packet_out(to_mem), .to_mem_packet_ack_in(to_mem_ack),
    .from_mem_packet_in(from_mem), .from_mem_packet_ack_out(from_ack),
    .busy_out(busy), .error_out(err));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (to_mem[31] && to_mem_ack) txn <= txn + 1;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one full transaction for port p; nxt is what the requester presents after its ack
  task automatic serve(input int p, input logic [31:0] pkt, input logic [31:0] nxt, input bit bp, input bit wo);
    logic [31:0] rsp;
    logic [63:0] slice;
    int n;
    bit a, done;
    rsp = pkt ^ 32'h0000_5A00;
    slice = {32'h0, rsp} << (p * 32);
    n = 0;
    while (req_ack === 2'b00 && n < 20) begin tick(); n++; end
    chk("grant", {62'h0, req_ack}, 64'(1) << p);
    chk("to_mem_pkt", {32'h0, to_mem}, {32'h0, pkt});
    chk("busy_on", {63'h0, busy}, 64'h1);
    req[p*32 +: 32] = nxt;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      a = !bp || (cyc % 5 == 0);
      to_mem_ack = a;
      tick();
      to_mem_ack = 1'b0;
      chk("req_ack_pulse", {62'h0, req_ack}, 64'h0);
      chk("to_mem_hold", {32'h0, to_mem}, a ? 64'h0 : {32'h0, pkt});
      done = a;
      n++;
    end
    chk("mem_ack_timeout", {63'h0, done}, 64'h1);
    tick();
    from_mem = rsp;
    tick();
    chk("from_ack", {63'h0, from_ack}, 64'h1);
    chk("resp_owner", resp_out, slice);
    tick();
    from_mem = '0;
    chk("from_ack_once", {63'h0, from_ack}, 64'h0);
    chk("err", {63'h0, err}, {63'h0, exp_err});
    if (wo) begin
      resp_ack[1-p] = 1'b1;
      tick();
      resp_ack = '0;
      chk("wrong_owner_hold", resp_out, slice);
      chk("wrong_owner_busy", {63'h0, busy}, 64'h1);
    end
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      a = !bp || (cyc % 6 == 0);
      resp_ack[p] = a;
      tick();
      resp_ack = '0;
      chk("resp_hold", resp_out, a ? 64'h0 : slice);
      chk("busy_after", {63'h0, busy}, a ? 64'h0 : 64'h1);
      done = a;
      n++;
    end
    chk("owner_ack_timeout", {63'h0, done}, 64'h1);
  endtask

  initial begin
    tick();
    tick();
    reset_in = 1'b0;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    chk("rst_to_mem", {32'h0, to_mem}, 64'h0);
    chk("rst_req_ack", {62'h0, req_ack}, 64'h0);
    chk("rst_resp", resp_out, 64'h0);
    chk("rst_from_ack", {63'h0, from_ack}, 64'h0);
    tick();
    chk("idle_no_req", {63'h0, busy}, 64'h0);
    // single read from port 0
    req[31:0] = 32'h8000_0001;
    serve(0, 32'h8000_0001, 32'h0, 1'b0, 1'b0);
    // stray response while idle
    from_mem = 32'h8000_00AA;
    tick();
    chk("stray_ack", {63'h0, from_ack}, 64'h1);
    chk("stray_err", {63'h0, err}, 64'h1);
    chk("stray_resp", resp_out, 64'h0);
    chk("stray_busy", {63'h0, busy}, 64'h0);
    tick();
    from_mem = '0;
    chk("stray_ack_once", {63'h0, from_ack}, 64'h0);
    exp_err = 1'b1;
    req[63:32] = 32'h8000_0102;
    serve(1, 32'h8000_0102, 32'h0, 1'b0, 1'b0);
    // reset while waiting for memory
    req[63:32] = 32'h8000_0123;
    tick();
    chk("mid_grant", {62'h0, req_ack}, 64'h2);
    req[63:32] = '0;
    to_mem_ack = 1'b1;
    tick();
    to_mem_ack = 1'b0;
    chk("mid_wait_busy", {63'h0, busy}, 64'h1);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    exp_err = 1'b0;
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_err", {63'h0, err}, 64'h0);
    chk("mid_rst_to_mem", {32'h0, to_mem}, 64'h0);
    chk("mid_rst_resp", resp_out, 64'h0);
    chk("mid_rst_acks", {61'h0, req_ack, from_ack}, 64'h0);
    req[63:32] = 32'h8000_0122;
    serve(1, 32'h8000_0122, 32'h0, 1'b0, 1'b1);
    // contention: both ports hold four packets each
    t0 = txn;
    req = {32'h8000_0110, 32'h8000_0010};
    for (int k = 0; k < 4; k++) begin
      serve(0, 32'h8000_0010 + 32'(k), k < 3 ? 32'h8000_0011 + 32'(k) : 32'h0, 1'b0, 1'b0);
      serve(1, 32'h8000_0110 + 32'(k), k < 3 ? 32'h8000_0111 + 32'(k) : 32'h0, 1'b0, 1'b0);
    end
    chk("txn_count", 64'(txn - t0), 64'd8);
    // back-pressure on memory and owner acks
    req = {32'h8000_0131, 32'h8000_0030};
    serve(0, 32'h8000_0030, 32'h0, 1'b1, 1'b0);
    serve(1, 32'h8000_0131, 32'h0, 1'b1, 1'b0);
    tick();
    chk("final_idle", {63'h0, busy}, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
